// File: rtl/iic_pkg.sv
// iic_pkg: shared I2C constants and target FSM state encoding.
// Holds the default EEPROM device address and the R/W bit encodings.
package iic_pkg;

    localparam logic [6:0] IIC_DEV_ADDR = 7'b1010000;

    localparam logic IIC_RW_WRITE = 1'b0;
    localparam logic IIC_RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEVADDR,
        ST_DEVACK,
        ST_WADDR,
        ST_WADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_MACK,
        ST_WAIT_STOP
    } iic_state_e;

endpackage

// File: rtl/iic_bus_sync.sv
// iic_bus_sync: 2-FF synchronizers for SCL/SDA plus edge and START/STOP pulses.
// Ports: clk, rst_n, scl_i, sda_i in; sda_o (synced), rise_o, fall_o, start_o, stop_o out.
module iic_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic rise_o,
    output logic fall_o,
    output logic start_o,
    output logic stop_o
);

    // [0] first stage, [1] synced sample
    logic [1:0] scl_meta_q;
    logic [1:0] sda_meta_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_s;
    logic       sda_s;

    // Reset to the idle bus level so no edge fires out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_q <= 2'b11;
            sda_meta_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= {scl_meta_q[0], scl_i};
            sda_meta_q <= {sda_meta_q[0], sda_i};
            scl_prev_q <= scl_meta_q[1];
            sda_prev_q <= sda_meta_q[1];
        end
    end

    assign scl_s = scl_meta_q[1];
    assign sda_s = sda_meta_q[1];

    assign sda_o   = sda_s;
    assign rise_o  = scl_s & ~scl_prev_q;
    assign fall_o  = ~scl_s & scl_prev_q;
    // SCL high on both samples, so SDA moving with an SCL fall is plain data
    assign start_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/iic_slave_eeprom.sv
// iic_slave_eeprom: I2C target emulating a 24Cxx EEPROM over an external sync memory.
// Ports: clk, rst_n, SCL, SDA (open-drain), mem_addr/wdata/we/rdata, busy, oDone {wr,rd}.
module iic_slave_eeprom
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = IIC_DEV_ADDR,
    parameter int         AW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          SCL,
    inout  wire           SDA,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic [1:0]    oDone
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic sda_s, rise, fall, start, stop;

    iic_bus_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_i   (SCL),
        .sda_i   (SDA),
        .sda_o   (sda_s),
        .rise_o  (rise),
        .fall_o  (fall),
        .start_o (start),
        .stop_o  (stop)
    );

    iic_state_e    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          mack_q, mack_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    tx_q, tx_d;
    logic          oe_q, oe_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          busy_q, busy_d;
    logic          wrote_q, wrote_d;
    logic          read_q, read_d;
    logic          we_q, we_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [1:0]    done_q, done_d;

    logic rx_phase;
    logic byte_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd7;
            full_q  <= 1'b0;
            mack_q  <= 1'b0;
            rx_q    <= 8'h00;
            tx_q    <= 8'h00;
            oe_q    <= 1'b0;
            ptr_q   <= '0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            wrote_q <= 1'b0;
            read_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            mack_q  <= mack_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            oe_q    <= oe_d;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            wrote_q <= wrote_d;
            read_q  <= read_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign rx_phase = (state_q == ST_DEVADDR) ||
                      (state_q == ST_WADDR)   ||
                      (state_q == ST_WDATA);
    // full_q marks that bit 0 was sampled; the following fall closes the byte
    assign byte_end = fall & full_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        mack_d  = mack_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        oe_d    = oe_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        busy_d  = busy_q;
        wrote_d = wrote_q;
        read_d  = read_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        done_d  = 2'b00;

        // Post-write increment lands one clk after the strobe
        if (we_q) begin
            ptr_d = ptr_q + PTR_ONE;
        end

        if (stop) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            full_d  = 1'b0;
            mack_d  = 1'b0;
            done_d  = {wrote_q, read_q};
            wrote_d = 1'b0;
            read_d  = 1'b0;
        end else if (start) begin
            state_d = ST_DEVADDR;
            cnt_d   = 3'd7;
            full_d  = 1'b0;
            mack_d  = 1'b0;
            oe_d    = 1'b0;
            if (state_q == ST_IDLE) begin
                wrote_d = 1'b0;
                read_d  = 1'b0;
            end
        end else begin
            if (rx_phase && rise) begin
                rx_d  = {rx_q[6:0], sda_s};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    full_d = 1'b1;
                end
            end
            if (rx_phase && byte_end) begin
                full_d = 1'b0;
            end

            unique case (state_q)
                ST_DEVADDR: begin
                    if (byte_end) begin
                        if (rx_q[7:1] == DEV_ADDR) begin
                            oe_d    = 1'b1;
                            rw_d    = rx_q[0];
                            busy_d  = 1'b1;
                            state_d = ST_DEVACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_DEVACK: begin
                    if (fall) begin
                        oe_d  = 1'b0;
                        cnt_d = 3'd7;
                        if (rw_q == IIC_RW_READ) begin
                            tx_d    = mem_rdata;
                            oe_d    = ~mem_rdata[7];
                            state_d = ST_RDATA;
                        end else begin
                            state_d = ST_WADDR;
                        end
                    end
                end
                ST_WADDR: begin
                    if (byte_end) begin
                        ptr_d   = AW'(rx_q);
                        oe_d    = 1'b1;
                        state_d = ST_WADDR_ACK;
                    end
                end
                ST_WADDR_ACK, ST_WDATA_ACK: begin
                    if (fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = 3'd7;
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (byte_end) begin
                        we_d    = 1'b1;
                        wdata_d = rx_q;
                        wrote_d = 1'b1;
                        oe_d    = 1'b1;
                        state_d = ST_WDATA_ACK;
                    end
                end
                ST_RDATA: begin
                    if (fall) begin
                        if (cnt_q == 3'd0) begin
                            oe_d    = 1'b0;
                            read_d  = 1'b1;
                            mack_d  = 1'b0;
                            state_d = ST_RD_MACK;
                        end else begin
                            tx_d  = {tx_q[6:0], 1'b0};
                            oe_d  = ~tx_q[6];
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                ST_RD_MACK: begin
                    if (rise) begin
                        ptr_d = ptr_q + PTR_ONE;
                        if (sda_s) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            mack_d = 1'b1;
                        end
                    end else if (fall && mack_q) begin
                        // Pointer moved at the ACK rise, so rdata has settled
                        tx_d    = mem_rdata;
                        oe_d    = ~mem_rdata[7];
                        cnt_d   = 3'd7;
                        mack_d  = 1'b0;
                        state_d = ST_RDATA;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr  = ptr_q;
        mem_wdata = wdata_q;
        mem_we    = we_q;
        busy      = busy_q;
        oDone     = done_q;
    end

    assign SDA = oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_iic_slave_eeprom.sv
// tb_iic_slave_eeprom: bit-banged I2C master driving the EEPROM target.
// Table-driven single writes plus directed read, wrap, mismatch, abort and reset sequences.
`timescale 1ns/1ps
module tb_iic_slave_eeprom;

    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SCL = 1'b1;
    logic       m_low = 1'b0;
    logic       cond_win = 1'b0;
    wire        SDA;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_we;
    logic       busy;
    logic [1:0] oDone;

    assign SDA = m_low ? 1'b0 : 1'bz;
    pullup (SDA);

    iic_slave_eeprom dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SCL       (SCL),
        .SDA       (SDA),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .oDone     (oDone)
    );

    always #10 clk = ~clk;

    logic [7:0] mem [256];
    logic       filled = 1'b0;
    logic [7:0] we_a [$];
    logic [7:0] we_d [$];
    int         done_w = 0;
    int         done_r = 0;
    int         viol = 0;
    int         total = 0;
    int         bad = 0;

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            filled <= 1'b1;
        end else begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                we_a.push_back(mem_addr);
                we_d.push_back(mem_wdata);
            end
        end
        if (oDone[1]) done_w <= done_w + 1;
        if (oDone[0]) done_r <= done_r + 1;
    end

    // Only the master may move SDA while SCL is high (START/STOP)
    always @(SDA) begin
        if (SCL && !cond_win && rst_n) viol++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic m_bit(input logic b, output logic r);
        #Q; m_low = ~b;
        #Q; SCL = 1'b1;
        #Q; r = SDA;
        #Q; SCL = 1'b0;
    endtask

    task automatic m_start();
        #Q; m_low = 1'b0;
        #Q; SCL = 1'b1;
        #(2*Q); cond_win = 1'b1; m_low = 1'b1; #1 cond_win = 1'b0;
        #(2*Q-1); SCL = 1'b0;
    endtask

    task automatic m_stop();
        #Q; m_low = 1'b1;
        #Q; SCL = 1'b1;
        #(2*Q); cond_win = 1'b1; m_low = 1'b0; #1 cond_win = 1'b0;
        #(2*Q-1);
    endtask

    task automatic m_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(d[i], r);
        m_bit(1'b1, ack);
    endtask

    task automatic m_read(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, r);
            d[i] = r;
        end
        m_bit(nack, r);
    endtask

    typedef struct {
        logic [7:0] wa;
        logic [7:0] wd;
        logic [7:0] ptr_exp;
    } wvec_t;

    wvec_t      vt [4];
    logic       a0, a1, a2, r;
    logic [7:0] rd, b0, b1, b2;
    int         n0, dw, dr;

    initial begin
        vt[0] = '{8'h05, 8'h3C, 8'h06};
        vt[1] = '{8'h00, 8'hFF, 8'h01};
        vt[2] = '{8'hFF, 8'h00, 8'h00};
        vt[3] = '{8'h80, 8'hA5, 8'h81};

        #103;
        chk("rst_sda", SDA, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", oDone, 0);
        #100 rst_n = 1'b1;
        #(2*Q);

        for (int k = 0; k < 4; k++) begin
            n0 = we_a.size(); dw = done_w; dr = done_r;
            m_start();
            m_byte(8'hA0, a0);
            chk("w_devack", a0, 0);
            chk("w_busy", busy, 1);
            m_byte(vt[k].wa, a1);
            m_byte(vt[k].wd, a2);
            m_stop();
            chk("w_acks", {a1, a2}, 0);
            chk("w_we_cnt", we_a.size() - n0, 1);
            chk("w_we_addr", we_a[$], vt[k].wa);
            chk("w_we_data", we_d[$], vt[k].wd);
            chk("w_ptr", mem_addr, vt[k].ptr_exp);
            chk("w_done_w", done_w - dw, 1);
            chk("w_done_r", done_r - dr, 0);
            chk("w_busy_end", busy, 0);
        end

        // random read of 0x05
        dw = done_w; dr = done_r;
        m_start();
        m_byte(8'hA0, a0);
        m_byte(8'h05, a1);
        m_start();
        m_byte(8'hA1, a2);
        m_read(1'b1, rd);
        m_stop();
        chk("rr_acks", {a0, a1, a2}, 0);
        chk("rr_data", rd, 8'h3C);
        chk("rr_ptr", mem_addr, 8'h06);
        chk("rr_done_r", done_r - dr, 1);
        chk("rr_done_w", done_w - dw, 0);

        // sequential read across the pointer wrap
        m_start();
        m_byte(8'hA0, a0);
        m_byte(8'hFE, a1);
        m_start();
        m_byte(8'hA1, a2);
        m_read(1'b0, b0);
        m_read(1'b0, b1);
        m_read(1'b1, b2);
        m_stop();
        chk("sr_acks", {a0, a1, a2}, 0);
        chk("sr_b0", b0, 8'hA4);
        chk("sr_b1", b1, 8'h00);
        chk("sr_b2", b2, 8'hFF);
        chk("sr_ptr", mem_addr, 8'h01);

        // address mismatch, then a normal write
        n0 = we_a.size();
        m_start();
        m_byte(8'hB0, a0);
        chk("mm_nack", a0, 1);
        chk("mm_busy", busy, 0);
        m_stop();
        chk("mm_we", we_a.size() - n0, 0);
        m_start();
        m_byte(8'hA0, a0);
        m_byte(8'h20, a1);
        m_byte(8'h77, a2);
        m_stop();
        chk("mm2_acks", {a0, a1, a2}, 0);
        chk("mm2_we_addr", we_a[$], 8'h20);
        chk("mm2_we_data", we_d[$], 8'h77);

        // abort after a completed byte
        n0 = we_a.size(); dw = done_w;
        m_start();
        m_byte(8'hA0, a0);
        m_byte(8'h30, a1);
        m_byte(8'h11, a2);
        m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r); m_bit(1'b0, r);
        m_stop();
        chk("ab1_we_cnt", we_a.size() - n0, 1);
        chk("ab1_ptr", mem_addr, 8'h31);
        chk("ab1_done", done_w - dw, 1);

        // abort with no completed data byte
        n0 = we_a.size(); dw = done_w;
        m_start();
        m_byte(8'hA0, a0);
        m_byte(8'h40, a1);
        m_bit(1'b1, r); m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r);
        m_stop();
        chk("ab2_we_cnt", we_a.size() - n0, 0);
        chk("ab2_ptr", mem_addr, 8'h40);
        chk("ab2_done", done_w - dw, 0);

        // page write of four bytes
        n0 = we_a.size(); dw = done_w;
        m_start();
        m_byte(8'hA0, a0);
        m_byte(8'h10, a1);
        for (int j = 0; j < 4; j++) begin
            m_byte(8'hD0 + 8'(j), a2);
            chk("pg_ack", a2, 0);
        end
        m_stop();
        chk("pg_we_cnt", we_a.size() - n0, 4);
        for (int j = 0; j < 4; j++) begin
            chk("pg_addr", we_a[n0 + j], 8'h10 + 8'(j));
            chk("pg_data", we_d[n0 + j], 8'hD0 + 8'(j));
        end
        chk("pg_ptr", mem_addr, 8'h14);
        chk("pg_done", done_w - dw, 1);

        // async reset while the target drives a read bit
        m_start();
        m_byte(8'hA0, a0);
        m_byte(8'h05, a1);
        m_start();
        m_byte(8'hA1, a2);
        m_bit(1'b1, r);
        chk("rs_bit7", r, 0);
        #Q;
        chk("rs_drive", SDA, 0);
        chk("rs_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_sda", SDA, 1);
        chk("rs_busy", busy, 0);
        chk("rs_addr", mem_addr, 0);
        chk("rs_we", mem_we, 0);
        chk("rs_done", oDone, 0);
        #(Q-1) rst_n = 1'b1;
        #Q;
        m_stop();

        n0 = we_a.size();
        m_start();
        m_byte(8'hA0, a0);
        m_byte(8'h50, a1);
        m_byte(8'h66, a2);
        m_stop();
        chk("pr_acks", {a0, a1, a2}, 0);
        chk("pr_we_cnt", we_a.size() - n0, 1);
        chk("pr_we_addr", we_a[$], 8'h50);
        chk("pr_ptr", mem_addr, 8'h51);

        chk("sda_scl_high", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
